// File: rtl/id_ctrl_pipe_if.sv
// ID/EXE control bus for id_ctrl_pipe: ID operands, EXE/MEM hazard taps, branch
// resolution and the registered EXE control bundle with its stall/flush handshakes.
interface id_ctrl_pipe_if #(
  parameter int OPCODE_W   = 6,
  parameter int EXE_CMD_W  = 4,
  parameter int REG_ADDR_W = 5
);
  logic                  instr_valid;
  logic [OPCODE_W-1:0]   opcode;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic                  exe_mem_read;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  branch_taken;

  logic [EXE_CMD_W-1:0]  Exe_Cmd;
  logic                  mem_read;
  logic                  mem_write;
  logic                  WB_Enable;
  logic                  is_immediate;
  logic [1:0]            Branch_Type;
  logic                  ctl_valid;
  logic                  freeze;
  logic                  flush;
  logic                  mul_busy;

  modport master (
    output instr_valid, opcode, src1, src2, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken,
    input  Exe_Cmd, mem_read, mem_write, WB_Enable, is_immediate, Branch_Type,
           ctl_valid, freeze, flush, mul_busy
  );

  modport slave (
    input  instr_valid, opcode, src1, src2, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, branch_taken,
    output Exe_Cmd, mem_read, mem_write, WB_Enable, is_immediate, Branch_Type,
           ctl_valid, freeze, flush, mul_busy
  );
endinterface

// File: rtl/id_ctrl_pipe.sv
// Registered ID/EXE decode control with RAW hazard stall, branch flush and MUL sequencing.
// Optional macro FORWARDING_EN: with a forwarding unit present, only load-use hazards stall.
module id_ctrl_pipe #(
  parameter int OPCODE_W   = 6,
  parameter int EXE_CMD_W  = 4,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  id_ctrl_pipe_if.slave io_bus
);
  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_NOR  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_SLA  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_SLL  = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_SRA  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_SRL  = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(32);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(33);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(36);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(37);
  localparam logic [OPCODE_W-1:0] OP_BEZ  = OPCODE_W'(40);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(41);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(42);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

  typedef struct packed {
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_en;
    logic                 is_imm;
    logic [1:0]           br_type;
  } bundle_t;

  typedef enum logic {S_RUN, S_MUL_WAIT} state_t;

  function automatic bundle_t decode(input logic [OPCODE_W-1:0] op);
    bundle_t b;
    case (op)
      OP_ADD:         b = '{EXE_CMD_W'(0),  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_SUB:         b = '{EXE_CMD_W'(2),  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_AND:         b = '{EXE_CMD_W'(4),  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_OR:          b = '{EXE_CMD_W'(5),  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_NOR:         b = '{EXE_CMD_W'(6),  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_XOR:         b = '{EXE_CMD_W'(7),  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_SLA, OP_SLL: b = '{EXE_CMD_W'(8),  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_SRA:         b = '{EXE_CMD_W'(9),  1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_SRL:         b = '{EXE_CMD_W'(10), 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_MUL:         b = '{EXE_CMD_W'(11), 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
      OP_ADDI:        b = '{EXE_CMD_W'(0),  1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
      OP_SUBI:        b = '{EXE_CMD_W'(2),  1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
      OP_LD:          b = '{EXE_CMD_W'(0),  1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
      OP_ST:          b = '{EXE_CMD_W'(0),  1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
      OP_BEZ:         b = '{EXE_CMD_W'(0),  1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
      OP_BNE:         b = '{EXE_CMD_W'(0),  1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
      OP_JMP:         b = '{EXE_CMD_W'(0),  1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
      default:        b = '0;
    endcase
    return b;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  bundle_t    r_bundle, w_bundle_nxt, w_dec;
  logic       r_valid, w_valid_nxt;
  logic       r_mul_busy, w_mul_busy_nxt;
  logic       w_freeze;
  logic       w_use_src1, w_use_src2;
  logic       w_exe_match, w_mem_match;
  logic       w_hazard;
  logic       w_unused;

  assign w_dec      = decode(io_bus.opcode);
  assign w_use_src1 = (io_bus.opcode != OP_NOP) && (io_bus.opcode != OP_JMP);
  assign w_use_src2 = ((io_bus.opcode >= OP_ADD) && (io_bus.opcode <= OP_SRL)) ||
                      (io_bus.opcode == OP_ST) || (io_bus.opcode == OP_BNE);

  // r0 is hardwired zero, so a write to it never creates a dependency.
  assign w_exe_match = (io_bus.exe_dest != '0) &&
                       ((w_use_src1 && (io_bus.src1 == io_bus.exe_dest)) ||
                        (w_use_src2 && (io_bus.src2 == io_bus.exe_dest)));
  assign w_mem_match = (io_bus.mem_dest != '0) &&
                       ((w_use_src1 && (io_bus.src1 == io_bus.mem_dest)) ||
                        (w_use_src2 && (io_bus.src2 == io_bus.mem_dest)));

`ifdef FORWARDING_EN
  assign w_hazard = io_bus.instr_valid && io_bus.exe_mem_read && w_exe_match;
  assign w_unused = ^{io_bus.exe_wb_en, io_bus.mem_wb_en, w_mem_match};
`else
  assign w_hazard = io_bus.instr_valid &&
                    ((io_bus.exe_wb_en && w_exe_match) || (io_bus.mem_wb_en && w_mem_match));
  assign w_unused = io_bus.exe_mem_read;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bundle_nxt   = r_bundle;
    w_valid_nxt    = r_valid;
    w_mul_busy_nxt = r_mul_busy;
    w_freeze       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (io_bus.branch_taken) begin
          w_bundle_nxt   = '0;
          w_valid_nxt    = 1'b0;
          w_mul_busy_nxt = 1'b0;
        end else if (w_hazard) begin
          w_freeze       = 1'b1;
          w_bundle_nxt   = '0;
          w_valid_nxt    = 1'b0;
          w_mul_busy_nxt = 1'b0;
        end else begin
          w_bundle_nxt   = w_dec;
          w_valid_nxt    = io_bus.instr_valid;
          w_mul_busy_nxt = 1'b0;
          if (io_bus.instr_valid && (io_bus.opcode == OP_MUL)) begin
            w_state_nxt    = S_MUL_WAIT;
            w_cnt_nxt      = CNT_LOAD;
            w_mul_busy_nxt = 1'b1;
          end
        end
      end
      S_MUL_WAIT: begin
        // The bundle is still held on the exit edge, giving MUL its final EXE cycle in RUN.
        w_freeze  = 1'b1;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state    <= S_RUN;
      r_cnt      <= '0;
      r_bundle   <= '0;
      r_valid    <= 1'b0;
      r_mul_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bundle   <= w_bundle_nxt;
      r_valid    <= w_valid_nxt;
      r_mul_busy <= w_mul_busy_nxt;
    end
  end

  assign io_bus.Exe_Cmd      = r_bundle.exe_cmd;
  assign io_bus.mem_read     = r_bundle.mem_read;
  assign io_bus.mem_write    = r_bundle.mem_write;
  assign io_bus.WB_Enable    = r_bundle.wb_en;
  assign io_bus.is_immediate = r_bundle.is_imm;
  assign io_bus.Branch_Type  = r_bundle.br_type;
  assign io_bus.ctl_valid    = r_valid;
  assign io_bus.mul_busy     = r_mul_busy;
  assign io_bus.freeze       = w_freeze;
  assign io_bus.flush        = io_bus.branch_taken;
endmodule

// File: doc/id_ctrl_pipe.md
Name: id_ctrl_pipe

Overview:
- Registered, hazard-aware successor to the combinational decode control unit; sits at the ID/EXE boundary of the 5-stage pipeline.
- Decodes the ID-stage opcode into the EXE control bundle (Exe_Cmd, mem_read, mem_write, WB_Enable, is_immediate, Branch_Type) and registers it into EXE.
- Detects RAW hazards against the EXE and MEM stages and freezes fetch/decode. Inserts bubbles on stalls and taken branches.
- Sequences the new multi-cycle MUL opcode.

Parameters:
- OPCODE_W, 6, opcode width.
- EXE_CMD_W, 4, ALU command width.
- REG_ADDR_W, 5, register-address width.
- MUL_CYCLES, 4, EXE occupancy of MUL in cycles; legal range 2..15.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  ID holds a real instruction.
- opcode  in  OPCODE_W  ID opcode.
- src1  in  REG_ADDR_W  ID source register 1.
- src2  in  REG_ADDR_W  ID source register 2, or the store-data register for ST.
- exe_dest  in  REG_ADDR_W  destination of the instruction in EXE.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_read  in  1  EXE instruction is LD.
- mem_dest  in  REG_ADDR_W  destination of the instruction in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- branch_taken  in  1  EXE resolved a taken BEZ/BNE or a JMP.
- Exe_Cmd  out  EXE_CMD_W  registered ALU command.
- mem_read, mem_write, WB_Enable, is_immediate  out  1 each  registered controls.
- Branch_Type  out  2  registered branch type.
- ctl_valid  out  1  the EXE bundle is a real instruction, not a bubble.
- freeze  out  1  combinational; holds PC and the IF/ID register.
- flush  out  1  combinational; kills IF/ID contents.
- mul_busy  out  1  MUL is occupying EXE.

Behaviour:
- Decode table, bundle order {Exe_Cmd, mem_read, mem_write, WB_Enable, is_immediate, Branch_Type}:
  - NOP 0: all 0.
  - ADD 1: 0000,0,0,1,0,00.
  - SUB 3: 0010,0,0,1,0,00.
  - AND 5: 0100,0,0,1,0,00.
  - OR 6: 0101,0,0,1,0,00.
  - NOR 7: 0110,0,0,1,0,00.
  - XOR 8: 0111,0,0,1,0,00.
  - SLA 9 / SLL 10: 1000,0,0,1,0,00.
  - SRA 11: 1001,0,0,1,0,00.
  - SRL 12: 1010,0,0,1,0,00.
  - MUL 2 (new): 1011,0,0,1,0,00.
  - ADDI 32: 0000,0,0,1,1,00.
  - SUBI 33: 0010,0,0,1,1,00.
  - LD 36: 0000,1,0,1,1,00.
  - ST 37: 0000,0,1,0,1,00.
  - BEZ 40: 0000,0,0,0,0,01.
  - BNE 41: 0000,0,0,0,0,10.
  - JMP 42: 0000,0,0,0,0,11.
  - Undefined opcodes decode to an all-zero bundle. No X values are driven.
- Operand use:
  - src1 is used by all opcodes except NOP and JMP.
  - src2 is used by R-type (opcodes 1..12), ST and BNE.
  - Register 0 never causes a hazard.
- Hazard condition: instr_valid, and some used source equals exe_dest with exe_wb_en, or equals mem_dest with mem_wb_en.
- Bundle register reset: all outputs 0, ctl_valid 0, mul_busy 0, FSM in RUN.
- Latency: the bundle appears on the outputs 1 cycle after the opcode is sampled at the rising edge.
- Bubble: all-zero bundle with ctl_valid=0.
- FSM states:
  - RUN:
    - Hazard: freeze=1 and load a bubble.
    - Otherwise: load the decoded bundle, ctl_valid=instr_valid.
    - Decoded MUL without hazard: go to MUL_WAIT and load counter=MUL_CYCLES-1.
  - MUL_WAIT:
    - Hold the MUL bundle and ctl_valid=1; freeze=1; mul_busy=1; decrement the counter.
    - When the counter reaches 1, return to RUN on the next edge.
    - Net effect: MUL occupies EXE for exactly MUL_CYCLES cycles.
- branch_taken:
  - flush=1 combinationally.
  - The bundle register loads a bubble on the next edge, overriding hazard and decode.
  - branch_taken while in MUL_WAIT is illegal; it is asserted against by the bench only.
- Simultaneous hazard and branch_taken: flush wins; freeze=0.
- Reset mid-MUL: returns immediately to RUN with a zero bundle; no partial state survives.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: the forwarding unit exists. Only the load-use hazard stalls: a used source equals exe_dest with exe_mem_read=1. MEM-stage matches and non-load EXE matches do not stall.
- Undefined: the full RAW hazard rule above applies.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; after release, ADD (opcode 1) -> next edge Exe_Cmd=0000, WB_Enable=1, ctl_valid=1.
- RAW: EXE holds dest=3 with wb_en=1; ID has SUB src1=3 -> freeze=1 and one bubble; next cycle, with EXE clear, SUB issues Exe_Cmd=0010.
- Register 0: EXE dest=0 with wb_en=1; ID has ADD src1=0 -> no freeze.
- MUL with MUL_CYCLES=4 -> Exe_Cmd=1011 held for 4 cycles, mul_busy=1 for 4 cycles, freeze=1 for 3 cycles, then the next instruction issues.
- Branch: branch_taken=1 together with a hazard -> flush=1, freeze=0, next bundle is a bubble.
- FORWARDING_EN: EXE ADD dest=4, ID uses r4 -> no stall. EXE LD dest=4, ID uses r4 -> exactly one bubble.
